// File: rtl/jt03_busmaster.sv
// jt03_busmaster: queues (register, value) commands and replays each one on the
// jt03/YM2203 register port as busy-poll, address write, data write.
module jt03_busmaster #(
  parameter int FIFO_AW    = 4,
  parameter int STROBE_CYC = 2,
  parameter int BUSY_TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_reg,
  input  logic [7:0]       cmd_val,
  output logic [FIFO_AW:0] fifo_level,
  output logic             idle,
  output logic             cmd_done,
  output logic             tmo_err,
  input  logic             err_clr,
  output logic [7:0]       bus_din,
  output logic             bus_addr,
  output logic             bus_cs_n,
  output logic             bus_wr_n,
  input  logic [7:0]       bus_dout
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE, ST_POLL, ST_AWR, ST_GAP1, ST_DWR, ST_GAP2
  } state_t;

  // Command FIFO: {reg, val} per entry
  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ready_q;
  logic               push, pop;
  logic [7:0]         head_reg, head_val;

  // FSM state and counters
  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [7:0] poll_q, poll_d;
  logic       tmo_set;
  logic       last_strobe;
  logic       busy;

  // Registered bus outputs and their next values
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       done_q;
  logic       tmo_q;

  // Only the busy flag of the status byte matters here
  logic [6:0] unused_dout_bits;
  assign unused_dout_bits = bus_dout[6:0];

  assign busy        = bus_dout[7];
  assign push        = cmd_valid & ready_q;
  assign head_reg    = mem_q[rd_ptr_q][15:8];
  assign head_val    = mem_q[rd_ptr_q][7:0];
  assign last_strobe = (tick_q == 8'(STROBE_CYC - 1));

  // FIFO level bookkeeping: simultaneous push and pop leave the level unchanged
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage write port (contents need no reset, pointers define validity)
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_reg, cmd_val};
  end

  // FIFO pointers, level and ready flag; ready is held low while in reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != (FIFO_AW+1)'(DEPTH));
    end
  end

  // FSM state register with tick and poll counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      poll_q  <= poll_d;
    end
  end

  // FSM next-state logic; everything stays put unless cen is high
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    poll_d  = poll_q;
    tmo_set = 1'b0;
    pop     = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            state_d = ST_POLL;
            tick_d  = '0;
            poll_d  = '0;
          end
        end
        ST_POLL: begin
          if (tick_q == 8'd0) begin
            tick_d = 8'd1;
          end else begin
            tick_d = '0;
            if (!busy) begin
              state_d = ST_AWR;
            end else if (poll_q != 8'(BUSY_TMO)) begin
              poll_d = poll_q + 8'd1;
            end else begin
              tmo_set = 1'b1;
              state_d = ST_AWR;
            end
          end
        end
        ST_AWR: begin
          if (last_strobe) begin
            state_d = ST_GAP1;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
        ST_GAP1: begin
          state_d = ST_DWR;
          tick_d  = '0;
        end
        ST_DWR: begin
          if (last_strobe) begin
            pop     = 1'b1;
            state_d = ST_GAP2;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
        ST_GAP2: begin
          // A queued command goes straight to polling, saving the idle tick
          if (level_q != '0) begin
            state_d = ST_POLL;
            tick_d  = '0;
            poll_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next bus values; din/addr load only where cs_n falls
  always_comb begin
    cs_n_d = !(state_d == ST_POLL || state_d == ST_AWR || state_d == ST_DWR);
    wr_n_d = !(state_d == ST_AWR || state_d == ST_DWR);
    addr_d = addr_q;
    din_d  = din_q;
    if (state_d == ST_POLL && state_q != ST_POLL) begin
      addr_d = 1'b0;
      din_d  = head_reg;
    end else if (state_d == ST_DWR && state_q != ST_DWR) begin
      addr_d = 1'b1;
      din_d  = head_val;
    end
  end

  // Bus output registers, frozen while cen is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      addr_q <= 1'b0;
      din_q  <= '0;
    end else if (cen) begin
      cs_n_q <= cs_n_d;
      wr_n_q <= wr_n_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // Done pulse and sticky timeout flag (a new timeout beats a clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      done_q <= pop;
      if (tmo_set)      tmo_q <= 1'b1;
      else if (err_clr) tmo_q <= 1'b0;
    end
  end

  assign cmd_ready  = ready_q;
  assign fifo_level = level_q;
  assign idle       = (state_q == ST_IDLE) && (level_q == '0);
  assign cmd_done   = done_q;
  assign tmo_err    = tmo_q;
  assign bus_din    = din_q;
  assign bus_addr   = addr_q;
  assign bus_cs_n   = cs_n_q;
  assign bus_wr_n   = wr_n_q;

endmodule

// File: tb/tb_jt03_busmaster.sv
// Directed bench for jt03_busmaster: one instance with default timing and
// cen=1, one with STROBE_CYC=1 driven by a cen every third clock.
module tb_jt03_busmaster;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // Instance A
  logic       cen_a, cmd_valid, cmd_ready, err_clr, idle, cmd_done, tmo_err;
  logic [7:0] cmd_reg, cmd_val, bus_din, bus_dout;
  logic [4:0] fifo_level;
  logic       bus_addr, bus_cs_n, bus_wr_n;
  // Instance B
  logic       cen_b, cmd_valid_b, cmd_ready_b, err_clr_b, idle_b, cmd_done_b, tmo_err_b;
  logic [7:0] cmd_reg_b, cmd_val_b, bus_din_b, bus_dout_b;
  logic [4:0] fifo_level_b;
  logic       bus_addr_b, bus_cs_n_b, bus_wr_n_b;

  jt03_busmaster u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
    .fifo_level(fifo_level), .idle(idle), .cmd_done(cmd_done), .tmo_err(tmo_err),
    .err_clr(err_clr), .bus_din(bus_din), .bus_addr(bus_addr), .bus_cs_n(bus_cs_n),
    .bus_wr_n(bus_wr_n), .bus_dout(bus_dout)
  );

  jt03_busmaster #(.STROBE_CYC(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_reg(cmd_reg_b), .cmd_val(cmd_val_b),
    .fifo_level(fifo_level_b), .idle(idle_b), .cmd_done(cmd_done_b), .tmo_err(tmo_err_b),
    .err_clr(err_clr_b), .bus_din(bus_din_b), .bus_addr(bus_addr_b), .bus_cs_n(bus_cs_n_b),
    .bus_wr_n(bus_wr_n_b), .bus_dout(bus_dout_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts every comparison and reports mismatches
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write-strobe monitors: one record per wr_n low run
  typedef struct {
    logic       addr;
    logic [7:0] din;
    int         len;
    int         start;
  } wr_t;

  wr_t  wq_a[$];
  wr_t  wq_b[$];
  int   dq_a[$];
  wr_t  cur_a, cur_b;
  logic prev_a = 1'b1, prev_b = 1'b1;
  int   stab_a = 0, stab_b = 0, done_hi_b = 0;

  always @(negedge clk) begin
    if (bus_wr_n === 1'b0) begin
      if (prev_a !== 1'b0) begin
        cur_a.addr = bus_addr; cur_a.din = bus_din; cur_a.len = 1; cur_a.start = cyc;
      end else begin
        cur_a.len = cur_a.len + 1;
        if (bus_addr !== cur_a.addr || bus_din !== cur_a.din) stab_a++;
      end
    end else if (prev_a === 1'b0) begin
      wq_a.push_back(cur_a);
    end
    prev_a = bus_wr_n;
    if (cmd_done === 1'b1) dq_a.push_back(cyc);
  end

  always @(negedge clk) begin
    if (bus_wr_n_b === 1'b0) begin
      if (prev_b !== 1'b0) begin
        cur_b.addr = bus_addr_b; cur_b.din = bus_din_b; cur_b.len = 1; cur_b.start = cyc;
      end else begin
        cur_b.len = cur_b.len + 1;
        if (bus_addr_b !== cur_b.addr || bus_din_b !== cur_b.din) stab_b++;
      end
    end else if (prev_b === 1'b0) begin
      wq_b.push_back(cur_b);
    end
    prev_b = bus_wr_n_b;
    if (cmd_done_b === 1'b1) done_hi_b++;
  end

  // cen for instance B: high one clock in three
  initial begin
    int div = 0;
    cen_b = 1'b0;
    forever begin
      @(negedge clk);
      div   = (div == 2) ? 0 : div + 1;
      cen_b = (div == 0);
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    cmd_valid = 1'b1; cmd_reg = r; cmd_val = v;
    step;
    cmd_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int which, input int bound, input string tag);
    int n = 0;
    while (((which == 0) ? idle : idle_b) !== 1'b1 && n < bound) begin
      step;
      n++;
    end
    chk({tag, "_wait"}, 32'(n < bound), 1);
  endtask

  task automatic wait_tmo(input int bound, input string tag, output int rel);
    int n = 0;
    while (tmo_err !== 1'b1 && n < bound) begin
      step;
      n++;
    end
    chk({tag, "_wait"}, 32'(n < bound), 1);
    rel = cyc - t0;
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic a, input logic [7:0] d,
                        input int len, input int start);
    if (idx < wq_a.size()) begin
      chk({tag, "_addr"}, 32'(wq_a[idx].addr), 32'(a));
      chk({tag, "_din"}, 32'(wq_a[idx].din), 32'(d));
      chk({tag, "_len"}, 32'(wq_a[idx].len), 32'(len));
      if (start >= 0) chk({tag, "_start"}, 32'(wq_a[idx].start - t0), 32'(start));
    end else begin
      chk({tag, "_missing"}, 0, 1);
    end
  endtask

  // Single-write timing table, relative cycles 1..9: {cs_n, wr_n, addr, cmd_done, idle}
  logic [4:0] t2_ctl [9] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b11000,
                             5'b00100, 5'b00100, 5'b11110, 5'b11101};
  // {check, din}
  logic [8:0] t2_din [9] = '{9'h000, 9'h000, 9'h128, 9'h128, 9'h128,
                             9'h1F0, 9'h1F0, 9'h1F0, 9'h000};

  initial begin
    int rel, wb, db, acc;
    rst_n = 1'b0; cen_a = 1'b1;
    cmd_valid = 1'b0; cmd_reg = '0; cmd_val = '0; err_clr = 1'b0; bus_dout = '0;
    cmd_valid_b = 1'b0; cmd_reg_b = '0; cmd_val_b = '0; err_clr_b = 1'b0; bus_dout_b = '0;

    // Power-up reset state
    step; step;
    chk("rst_strobes", {bus_cs_n, bus_wr_n, bus_addr}, 3'b110);
    chk("rst_din", bus_din, 8'h00);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_tmo", tmo_err, 0);
    rst_n = 1'b1;
    step;
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_idle", idle, 1);

    // Single write, cycle-exact
    push(8'h28, 8'hF0);
    for (int n = 1; n <= 9; n++) begin
      step;
      chk($sformatf("t2_ctl_c%0d", n), {bus_cs_n, bus_wr_n, bus_addr, cmd_done, idle}, t2_ctl[n-1]);
      if (t2_din[n-1][8]) chk($sformatf("t2_din_c%0d", n), bus_din, t2_din[n-1][7:0]);
    end

    // Busy for five polls, then released
    wb = wq_a.size(); db = dq_a.size();
    bus_dout = 8'h80;
    push(8'h10, 8'h55);
    acc = 0;
    for (int n = 1; n <= 11; n++) begin
      step;
      if (bus_wr_n !== 1'b1) acc++;
    end
    chk("t3_no_early_wr", acc, 0);
    bus_dout = 8'h00;
    wait_idle(0, 100, "t3");
    chk("t3_nwr", wq_a.size() - wb, 2);
    chk_wr("t3_a", wb, 1'b0, 8'h10, 2, 13);
    chk_wr("t3_d", wb + 1, 1'b1, 8'h55, 2, 16);
    if (dq_a.size() > db) chk("t3_done_cyc", dq_a[db] - t0, 18);
    else chk("t3_done_missing", 0, 1);
    chk("t3_tmo", tmo_err, 0);

    // Busy stuck: timeout after 256 samples, write still issued
    wb = wq_a.size();
    bus_dout = 8'h80;
    push(8'h22, 8'h33);
    wait_tmo(700, "t4", rel);
    chk("t4_tmo_cyc", rel, 513);
    wait_idle(0, 50, "t4");
    chk_wr("t4_a", wb, 1'b0, 8'h22, 2, 513);
    chk_wr("t4_d", wb + 1, 1'b1, 8'h33, 2, 516);
    chk("t4_tmo_sticky", tmo_err, 1);

    // Reset in the middle of a data phase, with a second command queued
    bus_dout = 8'h00;
    cmd_valid = 1'b1; cmd_reg = 8'h44; cmd_val = 8'h55;
    step;
    t0 = cyc;
    cmd_reg = 8'h66; cmd_val = 8'h77;
    step;
    cmd_valid = 1'b0;
    for (int n = 2; n <= 6; n++) step;
    chk("t1_in_dwr", {bus_wr_n, bus_addr}, 2'b01);
    rst_n = 1'b0;
    step;
    chk("t1_strobes", {bus_cs_n, bus_wr_n, bus_addr}, 3'b110);
    chk("t1_din", bus_din, 8'h00);
    chk("t1_level", fifo_level, 0);
    chk("t1_tmo", tmo_err, 0);
    chk("t1_done", cmd_done, 0);
    chk("t1_ready_in_rst", cmd_ready, 0);
    step; step;
    chk("t1_ready_in_rst3", cmd_ready, 0);
    rst_n = 1'b1;
    step;
    chk("t1_ready_after", cmd_ready, 1);
    chk("t1_idle", idle, 1);

    // Timeout again, then clear it with err_clr
    wb = wq_a.size();
    bus_dout = 8'h80;
    push(8'h2A, 8'h5A);
    wait_tmo(700, "t4b", rel);
    wait_idle(0, 50, "t4b");
    chk("t4b_nwr", wq_a.size() - wb, 2);
    chk("t4b_tmo_set", tmo_err, 1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("t4b_err_clr", tmo_err, 0);
    step;
    chk("t4b_err_stays", tmo_err, 0);

    // FIFO full: 17 pushes while busy, 16 accepted, replayed in order
    wb = wq_a.size(); db = dq_a.size();
    bus_dout = 8'h80;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      cmd_valid = 1'b1; cmd_reg = 8'h30 + 8'(i); cmd_val = 8'hA0 + 8'(i);
      if (cmd_ready === 1'b1) acc++;
      step;
    end
    cmd_valid = 1'b0;
    chk("t5_accepted", acc, 16);
    chk("t5_level", fifo_level, 16);
    chk("t5_ready", cmd_ready, 0);
    bus_dout = 8'h00;
    wait_idle(0, 400, "t5");
    chk("t5_nwr", wq_a.size() - wb, 32);
    chk("t5_ndone", dq_a.size() - db, 16);
    for (int i = 0; i < 16; i++) begin
      chk_wr($sformatf("t5_a%0d", i), wb + 2*i, 1'b0, 8'h30 + 8'(i), 2, -1);
      chk_wr($sformatf("t5_d%0d", i), wb + 2*i + 1, 1'b1, 8'hA0 + 8'(i), 2, -1);
    end
    if (dq_a.size() >= db + 3) chk("t5_done_gap", dq_a[db+2] - dq_a[db+1], 8);
    else chk("t5_done_gap_missing", 0, 1);
    chk("t5_tmo", tmo_err, 0);
    chk("a_wr_stable", stab_a, 0);

    // Instance B: cen every third clock, one-tick strobes
    cmd_valid_b = 1'b1; cmd_reg_b = 8'h28; cmd_val_b = 8'hF0;
    step;
    cmd_valid_b = 1'b0;
    wait_idle(1, 300, "t6");
    chk("t6_nwr", wq_b.size(), 2);
    if (wq_b.size() >= 2) begin
      chk("t6_a_addr", {wq_b[0].addr, wq_b[0].din}, 9'h028);
      chk("t6_a_len", wq_b[0].len, 3);
      chk("t6_d_addr", {wq_b[1].addr, wq_b[1].din}, 9'h1F0);
      chk("t6_d_len", wq_b[1].len, 3);
    end
    chk("t6_done_clks", done_hi_b, 1);
    chk("b_wr_stable", stab_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
